// File: rtl/relu_maxpool2_col.sv
// ReLU followed by 2x2 stride-2 max pooling over a stream of FP16 map columns.
// Even columns are reduced row-pairwise and held; the following odd column completes each pooled column.
module relu_maxpool2_col #(
  parameter int DATA_WIDTH = 16,
  parameter int COL_SIZE   = 2,
  parameter int MAP_COLS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] column_in  [COL_SIZE-1:0],
  output logic [DATA_WIDTH-1:0] column_out [COL_SIZE/2-1:0],
  output logic                  valid_out,
  output logic                  last_out
);

  localparam int OUT_SIZE = COL_SIZE / 2;
  localparam int IDX_W    = (MAP_COLS > 2) ? $clog2(MAP_COLS) : 1;
  localparam bit MAP_ODD  = (MAP_COLS % 2) == 1;
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(MAP_COLS - 1);
  localparam logic [IDX_W-1:0] LAST_PAIR_IDX = MAP_ODD ? IDX_W'(MAP_COLS - 2) : IDX_W'(MAP_COLS - 1);

  if ((COL_SIZE < 2) || ((COL_SIZE % 2) != 0) || (MAP_COLS < 2)) begin : g_param_check
    $fatal(1, "relu_maxpool2_col: COL_SIZE must be even and >= 2, MAP_COLS must be >= 2");
  end

  typedef enum logic {WAIT_EVEN, HOLD_EVEN} state_t;

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? '0 : x;
  endfunction

  // Operands are already non-negative, so the magnitude field orders them.
  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
  endfunction

  state_t                 state_q, state_d, cur_state;
  logic [IDX_W-1:0]       col_idx_q, col_idx_d, cur_idx;
  logic [DATA_WIDTH-1:0]  buf_q        [OUT_SIZE];
  logic [DATA_WIDTH-1:0]  pair_max     [OUT_SIZE];
  logic [DATA_WIDTH-1:0]  pooled       [OUT_SIZE];
  logic [DATA_WIDTH-1:0]  column_out_q [OUT_SIZE];
  logic                   valid_out_q, last_out_q;
  logic                   store_en, emit, last_d;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_SIZE; gi++) begin : g_pool
      assign pair_max[gi]   = max2(relu(column_in[2*gi]), relu(column_in[2*gi+1]));
      assign pooled[gi]     = max2(buf_q[gi], pair_max[gi]);
      assign column_out[gi] = column_out_q[gi];
    end
  endgenerate

  // clear restarts the map in the same cycle, so a coincident column is column 0.
  assign cur_state = clear ? WAIT_EVEN : state_q;
  assign cur_idx   = clear ? '0 : col_idx_q;

  always_comb begin
    state_d   = cur_state;
    col_idx_d = cur_idx;
    store_en  = 1'b0;
    emit      = 1'b0;
    last_d    = 1'b0;
    if (valid_in) begin
      col_idx_d = (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
      case (cur_state)
        WAIT_EVEN: begin
          // An unpaired trailing column of an odd-width map is dropped.
          if (!(MAP_ODD && (cur_idx == LAST_IDX))) begin
            store_en = 1'b1;
            state_d  = HOLD_EVEN;
          end
        end
        HOLD_EVEN: begin
          emit    = 1'b1;
          last_d  = (cur_idx == LAST_PAIR_IDX);
          state_d = WAIT_EVEN;
        end
        default: state_d = WAIT_EVEN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_EVEN;
      col_idx_q   <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      for (int i = 0; i < OUT_SIZE; i++) begin
        buf_q[i]        <= '0;
        column_out_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      valid_out_q <= emit;
      last_out_q  <= last_d;
      for (int i = 0; i < OUT_SIZE; i++) begin
        if (store_en) buf_q[i] <= pair_max[i];
        if (emit)     column_out_q[i] <= pooled[i];
      end
    end
  end

  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;

endmodule

// File: tb/tb_relu_maxpool2_col.sv
// Scoreboard bench for relu_maxpool2_col: a 2x2-map instance and a 4-row, 3-column-map instance.
module tb_relu_maxpool2_col;

  typedef struct packed {
    logic            last;
    logic [1:0][15:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_clear = 1'b0, a_valid_in = 1'b0, a_valid_out, a_last_out;
  logic [15:0] a_in  [1:0];
  logic [15:0] a_out [0:0];
  logic        b_clear = 1'b0, b_valid_in = 1'b0, b_valid_out, b_last_out;
  logic [15:0] b_in  [3:0];
  logic [15:0] b_out [1:0];

  relu_maxpool2_col #(.DATA_WIDTH(16), .COL_SIZE(2), .MAP_COLS(2)) u_dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .valid_in(a_valid_in), .column_in(a_in),
    .column_out(a_out), .valid_out(a_valid_out), .last_out(a_last_out));

  relu_maxpool2_col #(.DATA_WIDTH(16), .COL_SIZE(4), .MAP_COLS(3)) u_dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .valid_in(b_valid_in), .column_in(b_in),
    .column_out(b_out), .valid_out(b_valid_out), .last_out(b_last_out));

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  logic [1:0][15:0] last_exp [2];
  int pulse_cnt [2];
  int pos [2];
  logic [15:0] held [2][4];

  function automatic int cs(input int k); return (k == 0) ? 2 : 4; endfunction
  function automatic int mc(input int k); return (k == 0) ? 2 : 3; endfunction
  function automatic logic [15:0] relu(input logic [15:0] x); return x[15] ? 16'h0000 : x; endfunction
  function automatic logic [15:0] mx(input logic [15:0] a, input logic [15:0] b); return (a > b) ? a : b; endfunction

  // Reference: a map position counter; each odd position pools with the stored even column.
  task automatic model_step(input int k, input bit v, input bit clr, input logic [3:0][15:0] c);
    exp_t e;
    int lastpair;
    if (clr) pos[k] = 0;
    if (!v) return;
    lastpair = (mc(k) % 2 == 1) ? mc(k) - 2 : mc(k) - 1;
    if (pos[k] % 2 == 0) begin
      if (!((mc(k) % 2 == 1) && (pos[k] == mc(k) - 1)))
        for (int i = 0; i < 4; i++) held[k][i] = relu(c[i]);
    end else begin
      e = '0;
      for (int j = 0; j < cs(k) / 2; j++)
        e.v[j] = mx(mx(held[k][2*j], held[k][2*j+1]), mx(relu(c[2*j]), relu(c[2*j+1])));
      e.last = (pos[k] == lastpair);
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    pos[k] = (pos[k] + 1) % mc(k);
  endtask

  task automatic step(input bit va, input bit clra, input logic [3:0][15:0] ca,
                      input bit vb, input bit clrb, input logic [3:0][15:0] cb);
    @(negedge clk);
    a_valid_in = va; a_clear = clra; a_in[0] = ca[0]; a_in[1] = ca[1];
    b_valid_in = vb; b_clear = clrb;
    for (int i = 0; i < 4; i++) b_in[i] = cb[i];
    model_step(0, va, clra, ca);
    model_step(1, vb, clrb, cb);
  endtask

  task automatic stepa(input bit v, input bit clr, input logic [15:0] x0, input logic [15:0] x1);
    step(v, clr, {16'h0, 16'h0, x1, x0}, 1'b0, 1'b0, '0);
  endtask

  task automatic stepb(input bit v, input bit clr, input logic [3:0][15:0] c);
    step(1'b0, 1'b0, '0, v, clr, c);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    idle();
    #2 rst = 1'b1;
    pos[0] = 0; pos[1] = 0;
    last_exp[0] = '0; last_exp[1] = '0;
    #1;
    chk("rst_a_col",   {16'h0, a_out[0]}, 32'h0);
    chk("rst_a_flags", {30'h0, a_valid_out, a_last_out}, 32'h0);
    chk("rst_b_col",   {b_out[1], b_out[0]}, 32'h0);
    chk("rst_b_flags", {30'h0, b_valid_out, b_last_out}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic mon(input int k, input logic v, input logic l, input logic [1:0][15:0] o);
    exp_t e;
    bit ok;
    n_checks++;
    if (v) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        n_err++;
        $display("FAIL pool%0d unexpected valid_out actual=1 required=0", k);
      end else begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        ok = (l === e.last);
        for (int j = 0; j < cs(k) / 2; j++) if (o[j] !== e.v[j]) ok = 0;
        if (!ok) begin
          n_err++;
          $display("FAIL pool%0d actual=%h last=%b required=%h last=%b", k, o, l, e.v, e.last);
        end else
          $display("pool%0d out=%h last=%b", k, o, l);
        last_exp[k] = e.v;
        pulse_cnt[k]++;
      end
    end else begin
      ok = (l === 1'b0);
      for (int j = 0; j < cs(k) / 2; j++) if (o[j] !== last_exp[k][j]) ok = 0;
      if (!ok) begin
        n_err++;
        $display("FAIL hold%0d actual=%h last=%b required=%h last=0", k, o, l, last_exp[k]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      mon(0, a_valid_out, a_last_out, {16'h0, a_out[0]});
      mon(1, b_valid_out, b_last_out, {b_out[1], b_out[0]});
    end
  end

  initial begin
    int gap [2];
    int p0;
    logic [3:0][15:0] ra, rb;
    bit va, vb, ca, cb;
    a_in[0] = '0; a_in[1] = '0;
    for (int i = 0; i < 4; i++) b_in[i] = '0;
    pulse_cnt[0] = 0; pulse_cnt[1] = 0;
    pos[0] = 0; pos[1] = 0;
    last_exp[0] = '0; last_exp[1] = '0;
    #1 rst = 1'b1;
    #1;
    chk("init_a_col",   {16'h0, a_out[0]}, 32'h0);
    chk("init_a_flags", {30'h0, a_valid_out, a_last_out}, 32'h0);
    chk("init_b_col",   {b_out[1], b_out[0]}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    mon_en = 1'b1;

    // Basic pair
    stepa(1, 0, 16'h3C00, 16'h4000);
    stepa(1, 0, 16'h3800, 16'h4200);
    idle();
    chk("basic_col",   {16'h0, a_out[0]}, 32'h4200);
    chk("basic_flags", {30'h0, a_valid_out, a_last_out}, 32'h3);

    // All-negative columns, including -0
    stepa(1, 0, 16'hBC00, 16'hC000);
    stepa(1, 0, 16'hBC00, 16'h8000);
    idle();
    chk("neg_col",   {16'h0, a_out[0]}, 32'h0);
    chk("neg_valid", {31'h0, a_valid_out}, 32'h1);

    // clear with a column while holding: big held column must be dropped
    stepa(1, 0, 16'h7000, 16'h7000);
    stepa(1, 1, 16'h3C00, 16'h0000);
    stepa(1, 0, 16'h4000, 16'h0000);
    idle();
    chk("clear_col", {16'h0, a_out[0]}, 32'h4000);
    chk("clear_last", {31'h0, a_last_out}, 32'h1);
    stepa(1, 0, 16'h7000, 16'h7000);
    stepa(0, 1, 16'h0, 16'h0);
    stepa(1, 0, 16'h3000, 16'h3400);
    stepa(1, 0, 16'h3500, 16'hFC00);
    idle();
    chk("clear_idle_col", {16'h0, a_out[0]}, 32'h3500);

    // Odd-width map: third column dropped, next map pairs from its own column 0
    p0 = pulse_cnt[1];
    stepb(1, 0, {16'h4800, 16'h4400, 16'h4000, 16'h3C00});
    stepb(1, 0, {16'h4600, 16'h3800, 16'hC000, 16'h4A00});
    stepb(1, 0, {16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF});
    stepb(1, 0, {16'h3400, 16'h3000, 16'h2C00, 16'h2800});
    stepb(1, 0, {16'hB000, 16'h3100, 16'h2000, 16'h2E00});
    idle();
    chk("odd_col", {b_out[1], b_out[0]}, {16'h3400, 16'h2E00});
    chk("odd_last", {31'h0, b_last_out}, 32'h1);
    idle();
    chk("odd_pulses", pulse_cnt[1] - p0, 32'd2);

    // Reset between the even and odd column
    stepa(1, 0, 16'h5000, 16'h5000);
    stepb(1, 0, {16'h5000, 16'h5000, 16'h5000, 16'h5000});
    do_reset();
    stepa(1, 0, 16'h3C00, 16'h0000);
    stepa(1, 0, 16'h4000, 16'h3800);
    idle();
    chk("rst_pair_col", {16'h0, a_out[0]}, 32'h4000);

    // Random columns with 0..5 idle cycles between them and occasional clear
    gap[0] = 0; gap[1] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        ra[i] = 16'($urandom);
        rb[i] = 16'($urandom);
      end
      va = (gap[0] == 0);
      vb = (gap[1] == 0);
      gap[0] = va ? int'($urandom_range(0, 5)) : gap[0] - 1;
      gap[1] = vb ? int'($urandom_range(0, 5)) : gap[1] - 1;
      ca = ($urandom_range(0, 31) == 0);
      cb = ($urandom_range(0, 31) == 0);
      step(va, ca, ra, vb, cb, rb);
    end
    idle(); idle(); idle();
    chk("drain_q0", q0.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
